// File: rtl/instr_adr_gen_if.sv
// Bundle between the IA generation stage and its neighbours: redirects in, BTB training in, IA pair out to FD.
// The master modport is the stage itself; the slave modport is the FD/EX/MA side.
interface instr_adr_gen_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   fdReady;
    logic                   exRedirValid;
    logic [WORD_LENGTH-1:0] exRedirPstate0;
    logic [WORD_LENGTH-1:0] exRedirPstate1;
    logic                   maRedirValid;
    logic [WORD_LENGTH-1:0] maRedirPstate0;
    logic [WORD_LENGTH-1:0] maRedirPstate1;
    logic                   fdRedirValid;
    logic [WORD_LENGTH-1:0] fdRedirPstate1;
    logic                   btbUpdValid;
    logic [WORD_LENGTH-1:0] btbUpdPstate1;
    logic [WORD_LENGTH-1:0] btbUpdTarget;
    logic                   btbUpdTaken;
    logic                   iaFdValid;
    logic [WORD_LENGTH-1:0] iaFdPstate0;
    logic [WORD_LENGTH-1:0] iaFdPstate1;
    logic                   iaFdPredTaken;

    modport master (
        input  fdReady,
        input  exRedirValid, exRedirPstate0, exRedirPstate1,
        input  maRedirValid, maRedirPstate0, maRedirPstate1,
        input  fdRedirValid, fdRedirPstate1,
        input  btbUpdValid, btbUpdPstate1, btbUpdTarget, btbUpdTaken,
        output iaFdValid, iaFdPstate0, iaFdPstate1, iaFdPredTaken
    );

    modport slave (
        output fdReady,
        output exRedirValid, exRedirPstate0, exRedirPstate1,
        output maRedirValid, maRedirPstate0, maRedirPstate1,
        output fdRedirValid, fdRedirPstate1,
        output btbUpdValid, btbUpdPstate1, btbUpdTarget, btbUpdTaken,
        input  iaFdValid, iaFdPstate0, iaFdPstate1, iaFdPredTaken
    );
endinterface

// File: rtl/instr_adr_gen.sv
// Instruction address generation: IA register pair, next-IA priority select and a direct-mapped BTB
// with 2-bit saturating counters indexed by the current offset.
module instr_adr_gen #(
    parameter int                WORD_LENGTH   = 32,
    parameter int                BTB_ENTRIES   = 16,
    parameter int                INSTR_BYTES   = 4,
    parameter logic [WORD_LENGTH-1:0] RESET_PSTATE0 = '0,
    parameter logic [WORD_LENGTH-1:0] RESET_PSTATE1 = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_adr_gen_if.master    bus
);
    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = WORD_LENGTH - IDX_BITS - 2;

    logic [WORD_LENGTH-1:0] pstate0_reg, pstate0_next;
    logic [WORD_LENGTH-1:0] pstate1_reg, pstate1_next;
    logic                   ia_valid_reg, ia_valid_next;

    logic [BTB_ENTRIES-1:0] btb_valid_reg, btb_valid_next;
    logic [1:0]             ctr_reg  [BTB_ENTRIES];
    logic [1:0]             ctr_next [BTB_ENTRIES];
    logic [TAG_BITS-1:0]    tag_mem    [BTB_ENTRIES];
    logic [WORD_LENGTH-1:0] target_mem [BTB_ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_BITS-1:0] lk_tag, upd_tag;
    logic                pred_taken;

    assign lk_idx  = pstate1_reg[IDX_BITS+1:2];
    assign lk_tag  = pstate1_reg[WORD_LENGTH-1:IDX_BITS+2];
    assign upd_idx = bus.btbUpdPstate1[IDX_BITS+1:2];
    assign upd_tag = bus.btbUpdPstate1[WORD_LENGTH-1:IDX_BITS+2];

    // Lookup reads the registered entry, so a same-cycle update is only seen next cycle.
    assign pred_taken = btb_valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag) && ctr_reg[lk_idx][1];

    always_comb begin
        pstate0_next  = pstate0_reg;
        pstate1_next  = pstate1_reg;
        ia_valid_next = 1'b1;
        if (bus.exRedirValid) begin
            pstate0_next = bus.exRedirPstate0;
            pstate1_next = bus.exRedirPstate1;
        end else if (bus.maRedirValid) begin
            pstate0_next = bus.maRedirPstate0;
            pstate1_next = bus.maRedirPstate1;
        end else if (bus.fdRedirValid) begin
            pstate1_next = bus.fdRedirPstate1;
        end else if (ia_valid_reg && bus.fdReady) begin
            // Only an IA that was actually presented can be consumed by FD.
            if (pred_taken)
                pstate1_next = target_mem[lk_idx];
            else
                pstate1_next = pstate1_reg + WORD_LENGTH'(INSTR_BYTES);
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb_entry
            logic upd_sel;
            logic upd_hit;
            assign upd_sel = bus.btbUpdValid && (upd_idx == IDX_BITS'(gi));
            assign upd_hit = btb_valid_reg[gi] && (tag_mem[gi] == upd_tag);

            always_comb begin
                ctr_next[gi]       = ctr_reg[gi];
                btb_valid_next[gi] = btb_valid_reg[gi];
                if (upd_sel) begin
                    if (upd_hit) begin
                        if (bus.btbUpdTaken)
                            ctr_next[gi] = (ctr_reg[gi] == 2'b11) ? 2'b11 : ctr_reg[gi] + 2'b01;
                        else
                            ctr_next[gi] = (ctr_reg[gi] == 2'b00) ? 2'b00 : ctr_reg[gi] - 2'b01;
                    end else if (bus.btbUpdTaken) begin
                        ctr_next[gi]       = 2'b10;
                        btb_valid_next[gi] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate0_reg   <= RESET_PSTATE0;
            pstate1_reg   <= RESET_PSTATE1;
            ia_valid_reg  <= 1'b0;
            btb_valid_reg <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr_reg[i] <= 2'b00;
        end else begin
            pstate0_reg   <= pstate0_next;
            pstate1_reg   <= pstate1_next;
            ia_valid_reg  <= ia_valid_next;
            btb_valid_reg <= btb_valid_next;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr_reg[i] <= ctr_next[i];
        end
    end

    // Tag and target need no reset: the valid bit gates them. A taken update on a hit rewrites the
    // same tag, so one write path serves both retarget and allocate.
    always_ff @(posedge clk) begin
        if (!rst && bus.btbUpdValid && bus.btbUpdTaken) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= bus.btbUpdTarget;
        end
    end

    assign bus.iaFdValid     = ia_valid_reg;
    assign bus.iaFdPstate0   = pstate0_reg;
    assign bus.iaFdPstate1   = pstate1_reg;
    assign bus.iaFdPredTaken = pred_taken;
endmodule

// File: tb/tb_instr_adr_gen.sv
// Directed bench for instr_adr_gen: reset, sequential wrap, stall, redirect priority, BTB training,
// same-cycle update visibility and reset dropping an update.
module tb_instr_adr_gen;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_adr_gen_if #(.WORD_LENGTH(32)) bus ();

    instr_adr_gen #(
        .WORD_LENGTH  (32),
        .BTB_ENTRIES  (16),
        .INSTR_BYTES  (4),
        .RESET_PSTATE0(32'h0),
        .RESET_PSTATE1(32'h100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_ia(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                          input logic vld, input logic pt);
        chk({tag, ".p0"}, bus.iaFdPstate0, p0);
        chk({tag, ".p1"}, bus.iaFdPstate1, p1);
        chk({tag, ".vld"}, {31'b0, bus.iaFdValid}, {31'b0, vld});
        chk({tag, ".pt"}, {31'b0, bus.iaFdPredTaken}, {31'b0, pt});
    endtask

    task automatic ex_redir(input logic [31:0] p0, input logic [31:0] p1);
        bus.exRedirValid   = 1'b1;
        bus.exRedirPstate0 = p0;
        bus.exRedirPstate1 = p1;
        step();
        bus.exRedirValid   = 1'b0;
    endtask

    task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.btbUpdValid   = 1'b1;
        bus.btbUpdPstate1 = pc;
        bus.btbUpdTarget  = tgt;
        bus.btbUpdTaken   = taken;
        step();
        bus.btbUpdValid   = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.fdReady        = 1'b0;
        bus.exRedirValid   = 1'b0;
        bus.exRedirPstate0 = '0;
        bus.exRedirPstate1 = '0;
        bus.maRedirValid   = 1'b0;
        bus.maRedirPstate0 = '0;
        bus.maRedirPstate1 = '0;
        bus.fdRedirValid   = 1'b0;
        bus.fdRedirPstate1 = '0;
        bus.btbUpdValid    = 1'b0;
        bus.btbUpdPstate1  = '0;
        bus.btbUpdTarget   = '0;
        bus.btbUpdTaken    = 1'b0;

        // T1 reset
        step();
        chk_ia("rst1", 32'h0, 32'h100, 1'b0, 1'b0);
        step();
        chk_ia("rst2", 32'h0, 32'h100, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_ia("post_rst", 32'h0, 32'h100, 1'b1, 1'b0);

        // T2 sequential wrap, segment untouched
        ex_redir(32'hA, 32'hFFFF_FFF8);
        chk_ia("wrap_start", 32'hA, 32'hFFFF_FFF8, 1'b1, 1'b0);
        bus.fdReady = 1'b1;
        step();
        chk_ia("wrap_fffc", 32'hA, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step();
        chk_ia("wrap_zero", 32'hA, 32'h0, 1'b1, 1'b0);

        // T3 stall: FD redirect lands regardless of fdReady, then pair held
        bus.fdReady        = 1'b0;
        bus.fdRedirValid   = 1'b1;
        bus.fdRedirPstate1 = 32'h40;
        step();
        bus.fdRedirValid   = 1'b0;
        chk_ia("fd_redir", 32'hA, 32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ia("stall", 32'hA, 32'h40, 1'b1, 1'b0);
        end
        bus.fdReady = 1'b1;
        step();
        bus.fdReady = 1'b0;
        chk_ia("unstall", 32'hA, 32'h44, 1'b1, 1'b0);

        // T4 redirect priority
        bus.exRedirValid   = 1'b1; bus.exRedirPstate0 = 32'h1; bus.exRedirPstate1 = 32'h1000;
        bus.maRedirValid   = 1'b1; bus.maRedirPstate0 = 32'h2; bus.maRedirPstate1 = 32'h2000;
        bus.fdRedirValid   = 1'b1; bus.fdRedirPstate1 = 32'h3000;
        step();
        chk_ia("prio_ex", 32'h1, 32'h1000, 1'b1, 1'b0);
        bus.exRedirValid = 1'b0;
        step();
        chk_ia("prio_ma", 32'h2, 32'h2000, 1'b1, 1'b0);
        bus.maRedirValid = 1'b0;
        bus.fdRedirValid = 1'b0;

        // T5 allocate taken entry at 0x50, predict, then train down
        bus.exRedirValid = 1'b1; bus.exRedirPstate0 = 32'h0; bus.exRedirPstate1 = 32'h50;
        btb_upd(32'h50, 32'h200, 1'b1);
        bus.exRedirValid = 1'b0;
        chk_ia("btb_hit", 32'h0, 32'h50, 1'b1, 1'b1);
        bus.fdReady = 1'b1;
        step();
        bus.fdReady = 1'b0;
        chk_ia("btb_target", 32'h0, 32'h200, 1'b1, 1'b0);
        btb_upd(32'h50, 32'h0, 1'b0);
        btb_upd(32'h50, 32'h0, 1'b0);
        ex_redir(32'h0, 32'h50);
        chk_ia("btb_trained_nt", 32'h0, 32'h50, 1'b1, 1'b0);
        bus.fdReady = 1'b1;
        step();
        chk_ia("btb_seq", 32'h0, 32'h54, 1'b1, 1'b0);

        // T6 same-cycle update at current index is not seen by that cycle's lookup
        btb_upd(32'h54, 32'h300, 1'b1);
        bus.fdReady = 1'b0;
        chk_ia("same_cyc", 32'h0, 32'h58, 1'b1, 1'b0);
        ex_redir(32'h0, 32'h54);
        chk_ia("upd_visible", 32'h0, 32'h54, 1'b1, 1'b1);
        ex_redir(32'h0, 32'h94);
        chk_ia("tag_alias", 32'h0, 32'h94, 1'b1, 1'b0);

        // Reset wins over a concurrent redirect and update
        rst = 1'b1;
        bus.exRedirValid = 1'b1; bus.exRedirPstate0 = 32'h5; bus.exRedirPstate1 = 32'h60;
        btb_upd(32'h60, 32'h400, 1'b1);
        rst = 1'b0;
        chk_ia("rst_wins", 32'h0, 32'h100, 1'b0, 1'b0);
        ex_redir(32'h0, 32'h60);
        chk_ia("rst_drop_upd", 32'h0, 32'h60, 1'b1, 1'b0);
        ex_redir(32'h0, 32'h54);
        chk_ia("rst_clr_btb", 32'h0, 32'h54, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
